// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution window accumulator.
// The FSM walks each sample through a two-step byte-serial add.
package conv_pkg;

  localparam int BYTE_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/conv_window_accum_adder.sv
// 8-bit carry-lookahead adder: every carry is a flat AND-OR of generate/propagate terms.
// Gate reports the group generate, i.e. carry-out assuming a zero carry-in.
module Lookahead_8Bit #(
  parameter int N = 7
) (
  input  logic [N:0] A,
  input  logic [N:0] B,
  input  logic       Cin,
  output logic [N:0] S,
  output logic       Cout,
  output logic       Gate
);

  logic [N:0]   gen;
  logic [N:0]   prop;
  logic [N+1:0] carry;

  // Carry into bit i+1: any generate at j<=i whose path up to i propagates, or Cin propagated through all.
  function automatic logic lookahead(input logic [N:0] g, input logic [N:0] p,
                                     input logic cin, input int msb);
    logic c;
    logic run;
    c   = 1'b0;
    run = 1'b1;
    for (int j = msb; j >= 0; j--) begin
      c   = c | (run & g[j]);
      run = run & p[j];
    end
    return c | (run & cin);
  endfunction

  assign gen      = A & B;
  assign prop     = A ^ B;
  assign carry[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_carry
      assign carry[gi+1] = lookahead(gen, prop, Cin, gi);
    end
  endgenerate

  assign S    = prop ^ carry[N:0];
  assign Cout = carry[N+1];
  assign Gate = lookahead(gen, prop, 1'b0, N);

endmodule

// File: rtl/conv_window_accum.sv
// Sums TAPS unsigned bytes per window through one shared 8-bit adder (low byte, then high byte),
// with a sticky overflow flag and a valid/ready handshake on both sides.
module conv_window_accum
  import conv_pkg::*;
#(
  parameter int TAPS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(TAPS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BYTE_W-1:0]  op_q, op_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   tap_cnt_q, tap_cnt_d;

  logic [BYTE_W-1:0]  add_a;
  logic [BYTE_W-1:0]  add_b;
  logic               add_cin;
  logic [BYTE_W-1:0]  add_s;
  logic               add_cout;

  // Operand mux: the high-byte pass adds only the carry saved from the low-byte pass.
  always_comb begin
    add_a   = acc_q[BYTE_W-1:0];
    add_b   = op_q;
    add_cin = 1'b0;
    if (state_q == ADD_HI) begin
      add_a   = acc_q[ACC_W-1:BYTE_W];
      add_b   = '0;
      add_cin = carry_q;
    end
  end

  Lookahead_8Bit #(
    .N(7)
  ) u_adder (
    .A   (add_a),
    .B   (add_b),
    .Cin (add_cin),
    .S   (add_s),
    .Cout(add_cout),
    .Gate()
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    tap_cnt_d = tap_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          state_d = ADD_LO;
        end
      end
      ADD_LO: begin
        acc_d[BYTE_W-1:0] = add_s;
        carry_d           = add_cout;
        state_d           = ADD_HI;
      end
      ADD_HI: begin
        acc_d[ACC_W-1:BYTE_W] = add_s;
        ovf_d                 = ovf_q | add_cout;
        tap_cnt_d             = tap_cnt_q + 1'b1;
        state_d               = (tap_cnt_d == TAPS_CNT) ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          acc_d     = '0;
          ovf_d     = 1'b0;
          tap_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_conv_window_accum.sv
// Directed and randomized checks of conv_window_accum with TAPS=9 and TAPS=300 instances.
module tb_conv_window_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [7:0]  in_data_s   [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [15:0] out_sum_s   [2];
  logic        out_ovf_s   [2];

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt0 = 0;
  int hs_cnt1 = 0;

  always #5 clk = ~clk;

  conv_window_accum #(.TAPS(9)) dut9 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .out_sum(out_sum_s[0]), .out_ovf(out_ovf_s[0])
  );

  conv_window_accum #(.TAPS(300)) dut300 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .out_sum(out_sum_s[1]), .out_ovf(out_ovf_s[1])
  );

  always @(posedge clk) begin
    if (out_valid_s[0] && out_ready_s[0]) hs_cnt0 <= hs_cnt0 + 1;
    if (out_valid_s[1] && out_ready_s[1]) hs_cnt1 <= hs_cnt1 + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one sample and return just after the edge that accepts it.
  task automatic push(input int k, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid_s[k] = 1'b1;
    in_data_s[k]  = d;
    while (!in_ready_s[k] && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("push_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid_s[k] = 1'b0;
    in_data_s[k]  = 8'($urandom);
  endtask

  // Call right after the final push: result must appear exactly three cycles after the accept.
  task automatic expect_window(input int k, input logic [15:0] sum, input logic ovf, input string tag);
    @(negedge clk);
    check({tag, "_t1_valid"}, out_valid_s[k], 1'b0);
    check({tag, "_t1_ready"}, in_ready_s[k], 1'b0);
    @(negedge clk);
    check({tag, "_t2_valid"}, out_valid_s[k], 1'b0);
    @(negedge clk);
    check({tag, "_t3_valid"}, out_valid_s[k], 1'b1);
    check({tag, "_sum"}, out_sum_s[k], sum);
    check({tag, "_ovf"}, out_ovf_s[k], ovf);
    check({tag, "_out_ready"}, in_ready_s[k], 1'b0);
    if (out_ready_s[k]) begin
      @(negedge clk);
      check({tag, "_post_valid"}, out_valid_s[k], 1'b0);
      check({tag, "_post_ready"}, in_ready_s[k], 1'b1);
      check({tag, "_post_clear"}, {out_ovf_s[k], out_sum_s[k]}, 17'h0);
    end
  endtask

  initial begin
    int           model_sum;
    int           hs_before;
    int           win_cnt;
    int           windows_done;
    int           guard;
    logic [16:0]  exp_q[$];
    logic [7:0]   d;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k]  = 1'b0;
      in_data_s[k]   = 8'h00;
      out_ready_s[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("reset_out_valid", out_valid_s[k], 1'b0);
      check("reset_out_sum", out_sum_s[k], 16'h0);
      check("reset_out_ovf", out_ovf_s[k], 1'b0);
      check("reset_in_ready", in_ready_s[k], 1'b1);
    end

    for (int i = 1; i <= 9; i++) push(0, 8'(i));
    expect_window(0, 16'h002D, 1'b0, "seq1to9");
    check("seq1to9_handshakes", hs_cnt0, 1);

    for (int i = 0; i < 9; i++) push(0, 8'hFF);
    expect_window(0, 16'h08F7, 1'b0, "ff9");

    // Back-pressure: result must sit still while the consumer stalls and samples are offered.
    out_ready_s[0] = 1'b0;
    model_sum = 0;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      model_sum += d;
      push(0, d);
    end
    expect_window(0, 16'(model_sum), 1'b0, "hold");
    in_valid_s[0] = 1'b1;
    hs_before = hs_cnt0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data_s[0] = 8'($urandom);
      check("hold_valid", out_valid_s[0], 1'b1);
      check("hold_sum", out_sum_s[0], 16'(model_sum));
      check("hold_in_ready", in_ready_s[0], 1'b0);
    end
    out_ready_s[0] = 1'b1;
    in_valid_s[0]  = 1'b0;
    @(negedge clk);
    check("hold_release_valid", out_valid_s[0], 1'b0);
    check("hold_release_hs", hs_cnt0, hs_before + 1);

    // Mid-window reset discards the partial sum.
    for (int i = 0; i < 4; i++) push(0, 8'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", out_valid_s[0], 1'b0);
    check("midrst_sum", out_sum_s[0], 16'h0);
    check("midrst_in_ready", in_ready_s[0], 1'b1);
    hs_before = hs_cnt0;
    for (int i = 0; i < 9; i++) push(0, 8'h02);
    expect_window(0, 16'h0012, 1'b0, "midrst");
    check("midrst_hs", hs_cnt0, hs_before + 1);

    for (int i = 0; i < 300; i++) push(1, 8'hFF);
    expect_window(1, 16'h2AD4, 1'b1, "ff300");
    check("ff300_hs", hs_cnt1, 1);

    // Randomized stalls on both sides against a window-sum reference.
    model_sum    = 0;
    win_cnt      = 0;
    windows_done = 0;
    guard        = 0;
    while (windows_done < 100 && guard < 40000) begin
      @(negedge clk);
      guard++;
      in_valid_s[0]  = ($urandom_range(0, 3) != 0);
      in_data_s[0]   = 8'($urandom);
      out_ready_s[0] = ($urandom_range(0, 2) != 0);
      if (in_valid_s[0] && in_ready_s[0]) begin
        model_sum += in_data_s[0];
        win_cnt++;
        if (win_cnt == 9) begin
          exp_q.push_back({(model_sum >= 65536), 16'(model_sum)});
          model_sum = 0;
          win_cnt   = 0;
        end
      end
      if (out_valid_s[0]) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_valid", out_valid_s[0], 1'b0);
        end else begin
          check("rand_sum", {out_ovf_s[0], out_sum_s[0]}, exp_q[0]);
          if (out_ready_s[0]) begin
            void'(exp_q.pop_front());
            windows_done++;
          end
        end
      end
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    check("rand_windows", windows_done, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
